// File: rtl/updown_chk_if.sv
// Sample/result bus between a triangle-counter source and its sequence checker.
interface updown_chk_if #(
   parameter int W    = 8,
   parameter int ERRW = 16
);
   logic            valid;
   logic [W-1:0]    d;
   logic            clr;
   logic            locked;
   logic            dir;
   logic            err;
   logic [ERRW-1:0] err_cnt;
   logic            peak;
   logic            trough;

   modport master (output valid, d, clr,
                   input  locked, dir, err, err_cnt, peak, trough);
   modport slave  (input  valid, d, clr,
                   output locked, dir, err, err_cnt, peak, trough);
endinterface

// File: rtl/updown_chk.sv
// Triangle-sequence checker: acquires phase/direction from valid samples, then
// flags out-of-sequence values and pulses on peak and trough turnarounds.
module updown_chk #(
   parameter int W    = 8,
   parameter int ERRW = 16
) (
   input logic         clk,
   input logic         nrst,
   updown_chk_if.slave bus
);
   localparam logic [W-1:0] MAX = '1;

   typedef enum logic [1:0] {IDLE, ONE, UP, DOWN} state_t;

   state_t          st;
   logic [W-1:0]    prev;
   logic [W-1:0]    up_exp, dn_exp;
   logic            hit;
   logic            locked_q, dir_q, err_q, peak_q, trough_q;
   logic [ERRW-1:0] cnt_q;

   // Expected next value folds the turnaround at both ends of the range
   assign up_exp = (prev == MAX) ? MAX - W'(1) : prev + W'(1);
   assign dn_exp = (prev == '0)  ? W'(1)       : prev - W'(1);
   assign hit    = (st == UP) ? (bus.d == up_exp) : (bus.d == dn_exp);

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         st       <= IDLE;
         prev     <= '0;
         locked_q <= 1'b0;
         dir_q    <= 1'b0;
         err_q    <= 1'b0;
         peak_q   <= 1'b0;
         trough_q <= 1'b0;
         cnt_q    <= '0;
      end else begin
         err_q    <= 1'b0;
         peak_q   <= 1'b0;
         trough_q <= 1'b0;
         if (bus.clr) begin
            st       <= IDLE;
            prev     <= '0;
            locked_q <= 1'b0;
            dir_q    <= 1'b0;
            cnt_q    <= '0;
         end else if (bus.valid) begin
            prev <= bus.d;
            case (st)
               IDLE: st <= ONE;
               ONE: begin
                  if (prev != MAX && bus.d == prev + W'(1)) begin
                     st       <= UP;
                     locked_q <= 1'b1;
                     dir_q    <= 1'b1;
                  end else if (prev != '0 && bus.d == prev - W'(1)) begin
                     st       <= DOWN;
                     locked_q <= 1'b1;
                     dir_q    <= 1'b0;
                  end
               end
               UP, DOWN: begin
                  if (!hit) begin
                     // Resync from the offending value
                     st       <= ONE;
                     locked_q <= 1'b0;
                     dir_q    <= 1'b0;
                     err_q    <= 1'b1;
                     if (cnt_q != '1) cnt_q <= cnt_q + ERRW'(1);
                  end else if (st == UP) begin
                     peak_q <= (bus.d == MAX);
                     if (prev == MAX) begin
                        st    <= DOWN;
                        dir_q <= 1'b0;
                     end
                  end else begin
                     trough_q <= (bus.d == '0);
                     if (prev == '0) begin
                        st    <= UP;
                        dir_q <= 1'b1;
                     end
                  end
               end
               default: st <= IDLE;
            endcase
         end
      end
   end

   assign bus.locked  = locked_q;
   assign bus.dir     = dir_q;
   assign bus.err     = err_q;
   assign bus.err_cnt = cnt_q;
   assign bus.peak    = peak_q;
   assign bus.trough  = trough_q;
endmodule

// File: tb/tb_updown_chk.sv
// Bench for updown_chk: a W=8/ERRW=16 and a W=8/ERRW=2 instance share stimulus
// and are compared every cycle against a step-based triangle model.
module tb_updown_chk;
   localparam int W   = 8;
   localparam int MAX = 255;

   logic clk = 1'b0;
   logic nrst = 1'b0;
   logic valid = 1'b0;
   logic [W-1:0] d = '0;
   logic clr = 1'b0;

   int nchk = 0;
   int nerr = 0;
   int npeak = 0, ntrough = 0, nerrp = 0;

   always #5 clk = ~clk;

   updown_chk_if #(.W(W), .ERRW(16)) ifa ();
   updown_chk_if #(.W(W), .ERRW(2))  ifb ();

   assign ifa.valid = valid;
   assign ifa.d     = d;
   assign ifa.clr   = clr;
   assign ifb.valid = valid;
   assign ifb.d     = d;
   assign ifb.clr   = clr;

   updown_chk #(.W(W), .ERRW(16)) u_wide   (.clk(clk), .nrst(nrst), .bus(ifa));
   updown_chk #(.W(W), .ERRW(2))  u_narrow (.clk(clk), .nrst(nrst), .bus(ifb));

   task automatic chk(input string nm, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   // Model: phase 0 = nothing seen, 1 = one sample, 2 = locked with step +/-1
   int m_phase, m_prev, m_step, m_cnt, m_v, m_nx;
   bit e_locked, e_dir, e_err, e_peak, e_trough;

   always @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         m_phase = 0; m_prev = 0; m_step = 0; m_cnt = 0;
         e_locked = 0; e_dir = 0; e_err = 0; e_peak = 0; e_trough = 0;
      end else begin
         e_err = 0; e_peak = 0; e_trough = 0;
         if (clr) begin
            m_phase = 0; m_prev = 0; m_cnt = 0;
         end else if (valid) begin
            m_v = int'(d);
            if (m_phase == 0) m_phase = 1;
            else if (m_phase == 1) begin
               if (m_v - m_prev == 1 || m_v - m_prev == -1) begin
                  m_phase = 2;
                  m_step  = m_v - m_prev;
               end
            end else begin
               m_nx = m_prev + m_step;
               if (m_nx > MAX || m_nx < 0) begin
                  m_step = -m_step;
                  m_nx   = m_prev + m_step;
               end
               if (m_v == m_nx) begin
                  e_peak   = (m_step > 0 && m_v == MAX);
                  e_trough = (m_step < 0 && m_v == 0);
               end else begin
                  e_err   = 1;
                  m_cnt   = m_cnt + 1;
                  m_phase = 1;
               end
            end
            m_prev = m_v;
         end
         e_locked = (m_phase == 2);
         e_dir    = (m_phase == 2 && m_step > 0);
      end
   end

   always @(negedge clk) begin
      chk("locked",   int'(ifa.locked),  int'(e_locked));
      chk("dir",      int'(ifa.dir),     int'(e_dir));
      chk("err",      int'(ifa.err),     int'(e_err));
      chk("peak",     int'(ifa.peak),    int'(e_peak));
      chk("trough",   int'(ifa.trough),  int'(e_trough));
      chk("err_cnt",  int'(ifa.err_cnt), (m_cnt > 65535) ? 65535 : m_cnt);
      chk("n_locked", int'(ifb.locked),  int'(e_locked));
      chk("n_err",    int'(ifb.err),     int'(e_err));
      chk("n_errcnt", int'(ifb.err_cnt), (m_cnt > 3) ? 3 : m_cnt);
      if (ifa.peak)   npeak++;
      if (ifa.trough) ntrough++;
      if (ifb.err)    nerrp++;
   end

   task automatic smp(input int v);
      @(negedge clk);
      valid = 1'b1; clr = 1'b0; d = W'(v);
      @(posedge clk); #1;
   endtask

   task automatic idle();
      @(negedge clk);
      valid = 1'b0; clr = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic do_clr();
      @(negedge clk);
      valid = 1'b0; clr = 1'b1;
      @(posedge clk); #1;
   endtask

   // 40-sample up stream; corrupts up to nbad samples at i = 5, 12, 19, ...
   task automatic run_stream(input int nbad);
      int bad;
      bad = 0;
      do_clr();
      for (int i = 0; i < 40; i++) begin
         if (bad < nbad && i % 7 == 5) begin
            smp(i + 100);
            bad++;
         end else smp(i);
      end
   endtask

   initial begin
      #1000000;
      nerr++;
      $display("FAIL watchdog: got timeout expected finish");
      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end

   initial begin
      repeat (2) @(posedge clk);
      #1;
      chk("rst_locked", int'(ifa.locked), 0);
      chk("rst_cnt",    int'(ifa.err_cnt), 0);
      @(negedge clk) nrst = 1'b1;

      // Acquisition: lock after the second sample
      smp(0);
      chk("acq_locked0", int'(ifa.locked), 0);
      smp(1);
      chk("acq_locked1", int'(ifa.locked), 1);
      chk("acq_dir1",    int'(ifa.dir), 1);
      smp(2);
      chk("acq_cnt", int'(ifa.err_cnt), 0);

      // Full triangle sweep 0..255..0,1
      do_clr();
      npeak = 0; ntrough = 0; nerrp = 0;
      for (int i = 0; i <= 255; i++) smp(i);
      for (int i = 254; i >= 0; i--) begin
         smp(i);
         if (i == 254) chk("sweep_dirfall", int'(ifa.dir), 0);
      end
      smp(1);
      chk("sweep_dirrise", int'(ifa.dir), 1);
      idle();
      chk("sweep_peaks",   npeak, 1);
      chk("sweep_troughs", ntrough, 1);
      chk("sweep_errs",    nerrp, 0);

      // Skip in UP
      do_clr();
      smp(10); smp(11); smp(13);
      chk("skip_err",    int'(ifa.err), 1);
      chk("skip_locked", int'(ifa.locked), 0);
      chk("skip_cnt",    int'(ifa.err_cnt), 1);
      smp(14);
      chk("skip_relock", int'(ifa.locked), 1);
      smp(15);

      // Mid-stream start going down, then a repeat
      do_clr();
      npeak = 0;
      smp(255); smp(254);
      chk("down_locked", int'(ifa.locked), 1);
      chk("down_dir",    int'(ifa.dir), 0);
      smp(253); smp(253);
      chk("rep_err", int'(ifa.err), 1);
      chk("rep_cnt", int'(ifa.err_cnt), 1);
      chk("down_nopeak", npeak, 0);

      // Four errors, then clr together with a sample
      run_stream(4);
      chk("s4_cnt",    int'(ifa.err_cnt), 4);
      chk("s4_ncnt",   int'(ifb.err_cnt), 3);
      chk("s4_locked", int'(ifa.locked), 1);
      @(negedge clk);
      valid = 1'b1; clr = 1'b1; d = 8'd40;
      @(posedge clk); #1;
      chk("clrv_locked", int'(ifa.locked), 0);
      chk("clrv_cnt",    int'(ifa.err_cnt), 0);
      smp(41);
      chk("clrv_ignored", int'(ifa.locked), 0);

      // Saturation on the narrow counter
      nerrp = 0;
      run_stream(5);
      idle();
      chk("sat_pulses", nerrp, 5);
      chk("sat_ncnt",   int'(ifb.err_cnt), 3);
      chk("sat_cnt",    int'(ifa.err_cnt), 5);

      // Asynchronous reset mid-sweep
      do_clr();
      for (int i = 0; i < 10; i++) smp(i);
      #2 nrst = 1'b0;
      #1;
      chk("arst_locked", int'(ifa.locked), 0);
      chk("arst_dir",    int'(ifa.dir), 0);
      chk("arst_cnt",    int'(ifb.err_cnt), 0);
      @(negedge clk) nrst = 1'b1;
      smp(50);
      chk("arst_one", int'(ifa.locked), 0);
      smp(51);
      chk("arst_relock", int'(ifa.locked), 1);
      chk("arst_dir_up", int'(ifa.dir), 1);
      idle();
      idle();

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule

// File: doc/updown_chk.md
# updown_chk

Sequence checker for the bidirectional triangle counter output (0,1,…,2^W−1,2^W−2,…,0,1,…). It samples the counter value on a valid strobe and acquires phase and direction. Once locked, it flags every sample that breaks the triangle sequence and reports peak and trough turnarounds. It sits on the receive side of the counter bus in the example bench and in the checker layer of the UVM environment.

## Interface
- W, 8: counter width; legal range W ≥ 2.
- ERRW, 16: width of the saturating error counter.

- clk  in  1  clock, rising edge.
- nrst  in  1  reset; asynchronous, active-low.
- valid  in  1  sample strobe; d is consumed on a rising clk edge with valid=1. Driven from the counter's enable, delayed to align with q.
- d  in  W  observed counter value.
- clr  in  1  synchronous clear; returns FSM to IDLE and zeroes err_cnt.
- locked  out  1  1 while FSM is in UP or DOWN.
- dir  out  1  1 in UP, 0 in DOWN, IDLE or ONE.
- err  out  1  one-cycle pulse: locked sample mismatched its expected value.
- err_cnt  out  ERRW  number of err pulses since reset/clr; saturates at all-ones.
- peak  out  1  one-cycle pulse: sample d = MAX accepted in UP.
- trough  out  1  one-cycle pulse: sample d = 0 accepted in DOWN.

## Operation
- MAX = 2^W−1. All comparisons and ±1 are W-bit with no wrap. The case prev=MAX, +1 never occurs because it is handled as a turnaround.
- Internal register prev[W-1:0] holds the last accepted sample.
- Samples are ignored when valid=0; state, prev and all outputs hold, except the pulses, which return to 0.
- FSM states IDLE, ONE, UP, DOWN:
  - IDLE: on valid, prev←d, go to ONE. No err.
  - ONE (acquisition): on valid:
    - d = prev+1 with prev ≠ MAX → go to UP.
    - d = prev−1 with prev ≠ 0 → go to DOWN.
    - Otherwise stay in ONE.
    - prev←d in all cases. No err and no err_cnt change during acquisition.
  - UP: expected value exp = prev+1 if prev ≠ MAX; exp = MAX−1 if prev = MAX, and the next state on match is DOWN.
  - DOWN: exp = prev−1 if prev ≠ 0; exp = 1 if prev = 0, and the next state on match is UP.
  - On match in UP or DOWN: prev←d. Assert peak if in UP and d = MAX; assert trough if in DOWN and d = 0.
  - On mismatch in UP or DOWN: err=1, err_cnt increments (saturating), prev←d, go to ONE (resync from the offending value).
- clr: forces IDLE, clears err_cnt, prev and all pulses. clr has priority over valid; a sample in the clr cycle is discarded.
- A repeated value (d = prev) while locked is a mismatch.

## Timing
- All outputs are registered. They update on the same clk edge that consumes the sample and are visible in the following cycle (latency 1).
- Reset values: locked=0, dir=0, err=0, err_cnt=0, peak=0, trough=0; FSM in IDLE, prev=0.
- nrst asserted mid-operation clears everything immediately (asynchronously). The first valid sample after deassertion enters via IDLE.
- err, peak and trough are each high for exactly one cycle per qualifying sample. Back-to-back valid samples may produce pulses on consecutive cycles.
- Lock from IDLE needs 2 valid samples; locked rises in the cycle after the second sample. Resync after an error needs 1 further consistent sample.
- err and peak/trough are mutually exclusive for a given sample.
- Saturation: at err_cnt = 2^ERRW−1, further errors still pulse err but the count holds.

## Test plan
- Reset, then valid samples 0,1,2 (W=8) → locked=1 and dir=1 after sample 1; err never pulses; err_cnt=0.
- Full sweep 0…255…0,1 continuous → exactly one peak (after sample 255) and one trough (after the second 0); dir falls after sample 254 and rises after sample 1; zero err.
- Locked UP, samples 10,11,13,14,15 → err pulse after 13; err_cnt=1; locked=0 in the cycle after 13, back to 1 after 14.
- Start mid-stream with samples 255,254,253 → DOWN after 254, no peak pulse; then inject 253 again → err, err_cnt=1.
- ERRW=2, locked stream with 5 separate corrupted samples → err pulses 5 times; err_cnt ends at 3.
- clr and valid in the same cycle while locked with err_cnt=4 → next cycle locked=0, err_cnt=0, sample ignored. Then assert nrst mid-sweep → all outputs 0 immediately, and relock after 2 samples.
